// File: rtl/tick_burst_ctrl.sv
// Burst controller: latches a period and burst length on start, then emits
// that many single-cycle ticks spaced period+1 clocks apart.
module tick_burst_ctrl #(
   parameter int unsigned CNT_W   = 26,
   parameter int unsigned BURST_W = 8
) (
   input  logic               iClk,
   input  logic               iRst,
   input  logic               iStart,
   input  logic               iAbort,
   input  logic [CNT_W-1:0]   iPeriod,
   input  logic [BURST_W-1:0] iBurst,
   output logic               oTick,
   output logic               oBusy,
   output logic               oDone,
   output logic               oAborted,
   output logic [BURST_W-1:0] oRemaining
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t             state;
   state_t             stateNxt;

   logic [CNT_W-1:0]   rPer;
   logic [CNT_W-1:0]   rCnt;
   logic [BURST_W-1:0] rRem;

   logic [CNT_W-1:0]   perNxt;
   logic [CNT_W-1:0]   cntNxt;
   logic [BURST_W-1:0] remNxt;
   logic               tickNxt;
   logic               doneNxt;
   logic               abortedNxt;
   logic               busyNxt;

   logic               startOk;
   logic               terminal;
   logic               lastTick;

   assign startOk  = iStart && (iBurst != '0);
   assign terminal = (rCnt == rPer);
   assign lastTick = (rRem <= BURST_W'(1));

   // State register
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state <= IDLE;
      end else begin
         state <= stateNxt;
      end
   end

   // Next-state logic; abort takes priority over a terminal-count edge
   always_comb begin
      stateNxt = state;
      unique case (state)
         IDLE: begin
            if (startOk) begin
               stateNxt = RUN;
            end
         end
         RUN: begin
            if (iAbort) begin
               stateNxt = IDLE;
            end else if (terminal && lastTick) begin
               stateNxt = IDLE;
            end
         end
         default: stateNxt = IDLE;
      endcase
   end

   // Output / datapath next values, registered below
   always_comb begin
      perNxt     = rPer;
      cntNxt     = rCnt;
      remNxt     = rRem;
      tickNxt    = 1'b0;
      doneNxt    = 1'b0;
      abortedNxt = 1'b0;
      unique case (state)
         IDLE: begin
            if (iStart) begin
               if (iBurst != '0) begin
                  perNxt = iPeriod;
                  cntNxt = '0;
                  remNxt = iBurst;
               end else begin
                  remNxt  = '0;
                  doneNxt = 1'b1;
               end
            end
         end
         RUN: begin
            if (iAbort) begin
               abortedNxt = 1'b1;
            end else if (terminal) begin
               cntNxt  = '0;
               tickNxt = 1'b1;
               if (rRem != '0) begin
                  remNxt = rRem - BURST_W'(1);
               end
               if (lastTick) begin
                  doneNxt = 1'b1;
               end
            end else begin
               cntNxt = rCnt + CNT_W'(1);
            end
         end
         default: begin
            cntNxt = '0;
         end
      endcase
   end

   assign busyNxt = (stateNxt == RUN);

   // Datapath and output registers
   always_ff @(posedge iClk) begin
      if (iRst) begin
         rPer     <= '0;
         rCnt     <= '0;
         rRem     <= '0;
         oTick    <= 1'b0;
         oBusy    <= 1'b0;
         oDone    <= 1'b0;
         oAborted <= 1'b0;
      end else begin
         rPer     <= perNxt;
         rCnt     <= cntNxt;
         rRem     <= remNxt;
         oTick    <= tickNxt;
         oBusy    <= busyNxt;
         oDone    <= doneNxt;
         oAborted <= abortedNxt;
      end
   end

   assign oRemaining = rRem;

endmodule

// File: tb/tb_tick_burst_ctrl.sv
// Directed self-checking bench for tick_burst_ctrl.
module tb_tick_burst_ctrl;

   localparam int unsigned CNT_W   = 26;
   localparam int unsigned BURST_W = 8;

   logic               iClk;
   logic               iRst;
   logic               iStart;
   logic               iAbort;
   logic [CNT_W-1:0]   iPeriod;
   logic [BURST_W-1:0] iBurst;
   logic               oTick;
   logic               oBusy;
   logic               oDone;
   logic               oAborted;
   logic [BURST_W-1:0] oRemaining;

   int nCmp  = 0;
   int nFail = 0;
   int nTicks;

   tick_burst_ctrl #(.CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
      .iClk       (iClk),
      .iRst       (iRst),
      .iStart     (iStart),
      .iAbort     (iAbort),
      .iPeriod    (iPeriod),
      .iBurst     (iBurst),
      .oTick      (oTick),
      .oBusy      (oBusy),
      .oDone      (oDone),
      .oAborted   (oAborted),
      .oRemaining (oRemaining)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   task automatic step();
      @(posedge iClk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCmp++;
      assert (obs === exp)
      else begin
         nFail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expectOuts(input string tag, input bit t, input bit b, input bit d,
                             input bit a, input int r);
      check({tag, ".tick"},    32'(oTick),      32'(t));
      check({tag, ".busy"},    32'(oBusy),      32'(b));
      check({tag, ".done"},    32'(oDone),      32'(d));
      check({tag, ".aborted"}, 32'(oAborted),   32'(a));
      check({tag, ".rem"},     32'(oRemaining), 32'(r));
   endtask

   task automatic startBurst(input int p, input int b);
      iStart  = 1'b1;
      iPeriod = CNT_W'(p);
      iBurst  = BURST_W'(b);
      step();
      iStart  = 1'b0;
   endtask

   initial begin
      iRst    = 1'b1;
      iStart  = 1'b0;
      iAbort  = 1'b0;
      iPeriod = '0;
      iBurst  = '0;
      step();
      step();
      expectOuts("reset", 0, 0, 0, 0, 0);
      iRst = 1'b0;
      step();
      expectOuts("idle", 0, 0, 0, 0, 0);

      // P=3, B=2: ticks after edges 4 and 8
      startBurst(3, 2);
      expectOuts("p3b2.e0", 0, 1, 0, 0, 2);
      for (int k = 1; k <= 8; k++) begin
         step();
         expectOuts($sformatf("p3b2.e%0d", k), (k == 4 || k == 8), (k < 8), (k == 8), 0,
                    (k < 4) ? 2 : ((k < 8) ? 1 : 0));
      end
      step();
      expectOuts("p3b2.after", 0, 0, 0, 0, 0);

      // P=0, B=3: consecutive ticks
      startBurst(0, 3);
      expectOuts("p0b3.e0", 0, 1, 0, 0, 3);
      for (int k = 1; k <= 3; k++) begin
         step();
         expectOuts($sformatf("p0b3.e%0d", k), 1, (k < 3), (k == 3), 0, 3 - k);
      end
      step();
      expectOuts("p0b3.after", 0, 0, 0, 0, 0);

      // abort in IDLE is ignored
      iAbort = 1'b1;
      step();
      iAbort = 1'b0;
      expectOuts("idleabort", 0, 0, 0, 0, 0);

      // P=5, B=4, abort on the terminal edge of tick 2 (edge 12)
      startBurst(5, 4);
      expectOuts("abort.e0", 0, 1, 0, 0, 4);
      for (int k = 1; k <= 11; k++) begin
         step();
         expectOuts($sformatf("abort.e%0d", k), (k == 6), 1, 0, 0, (k < 6) ? 4 : 3);
      end
      iAbort = 1'b1;
      step();
      iAbort = 1'b0;
      expectOuts("abort.e12", 0, 0, 0, 1, 3);
      step();
      expectOuts("abort.e13", 0, 0, 0, 0, 3);

      // B=0: immediate done, remaining cleared
      startBurst(9, 0);
      expectOuts("b0.e0", 0, 0, 1, 0, 0);
      step();
      expectOuts("b0.e1", 0, 0, 0, 0, 0);

      // P=2, B=3 with an ignored start mid-burst
      startBurst(2, 3);
      expectOuts("ign.e0", 0, 1, 0, 0, 3);
      nTicks = 0;
      for (int k = 1; k <= 12; k++) begin
         if (k == 2) begin
            iStart  = 1'b1;
            iPeriod = CNT_W'(7);
            iBurst  = BURST_W'(9);
         end else begin
            iStart  = 1'b0;
         end
         step();
         if (oTick) nTicks++;
         expectOuts($sformatf("ign.e%0d", k), (k == 3 || k == 6 || k == 9), (k < 9), (k == 9), 0,
                    (k < 3) ? 3 : ((k < 6) ? 2 : ((k < 9) ? 1 : 0)));
      end
      check("ign.tickcount", 32'(nTicks), 32'd3);

      // reset mid-burst: silent termination, then a normal burst
      startBurst(4, 3);
      for (int k = 1; k <= 7; k++) begin
         step();
      end
      expectOuts("rst.pre", 0, 1, 0, 0, 2);
      iRst = 1'b1;
      step();
      iRst = 1'b0;
      expectOuts("rst.e8", 0, 0, 0, 0, 0);
      step();
      expectOuts("rst.e9", 0, 0, 0, 0, 0);
      startBurst(1, 2);
      expectOuts("post.e0", 0, 1, 0, 0, 2);
      for (int k = 1; k <= 4; k++) begin
         step();
         expectOuts($sformatf("post.e%0d", k), (k == 2 || k == 4), (k < 4), (k == 4), 0,
                    (k < 2) ? 2 : ((k < 4) ? 1 : 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

endmodule

// File: doc/tick_burst_ctrl.md
# tick_burst_ctrl

Programmable tick-burst controller that owns a terminal-count prescaler and sequences it. On a start request it latches a period and a burst length. It then emits exactly that many single-cycle ticks spaced `iPeriod+1` clocks apart, and reports completion or abort. It sits between control logic (FSMs, test sequencers) and any consumer that needs a bounded, evenly spaced train of enable pulses.

## Interface
Parameters:
- `CNT_W`, default 26, width of the period register and the internal prescaler counter.
- `BURST_W`, default 8, width of the burst-length and remaining-count fields.

Ports:
- `iClk`  in  1  clock; all state updates on the rising edge.
- `iRst`  in  1  reset, synchronous, active-high.
- `iStart`  in  1  start request; sampled only in IDLE.
- `iAbort`  in  1  abort request; sampled only in RUN.
- `iPeriod`  in  CNT_W  terminal count; tick spacing is `iPeriod+1` cycles. Latched at start.
- `iBurst`  in  BURST_W  number of ticks to emit. Latched at start.
- `oTick`  out  1  registered single-cycle tick.
- `oBusy`  out  1  high while in RUN.
- `oDone`  out  1  single-cycle pulse when a burst completes normally.
- `oAborted`  out  1  single-cycle pulse when a burst is aborted.
- `oRemaining`  out  BURST_W  ticks still to be emitted (registered).

## Operation
- Two states, IDLE and RUN. Internal registers: `rPer` (CNT_W), `rCnt` (CNT_W), `rRem` (BURST_W).
- Reset: state IDLE, `rPer`/`rCnt`/`rRem` = 0, all outputs 0. A reset asserted mid-burst terminates it silently: no `oDone`, no `oAborted`.
- IDLE, `iStart`=1, `iBurst`≠0, at edge E:
  - state becomes RUN, `rPer`=`iPeriod`, `rCnt`=0, `rRem`=`iBurst`.
  - `oBusy`=1 from E.
- IDLE, `iStart`=1, `iBurst`=0: stay in IDLE, `oDone` pulses for one cycle from E, `oRemaining`=0, no tick.
- IDLE: `iAbort` is ignored. `iStart` and `iAbort` together in IDLE means start is accepted.
- RUN, each edge without abort:
  - If `rCnt`≠`rPer`: `rCnt` increments by 1.
  - If `rCnt`==`rPer`: `rCnt` clears to 0, `oTick`=1 for one cycle, `rRem` decrements by 1.
  - If that terminal edge is taken with `rRem`==1: `rRem` becomes 0, state returns to IDLE, `oBusy`=0, and `oDone`=1 on the same edge as the final `oTick`.
- RUN, `iAbort`=1 at an edge: state returns to IDLE, `oAborted` pulses, `oBusy`=0, no `oTick`, no `oDone`. This holds even if that edge was a terminal-count edge, so abort wins. `rRem` holds its pre-edge value, which is visible on `oRemaining`.
- `iStart` in RUN is ignored. `iPeriod`/`iBurst` changes in RUN have no effect.
- `iPeriod`=0 is legal: one tick every cycle.
- Arithmetic: `rCnt` never exceeds `rPer`, so there is no wrap. `rRem` never decrements below 0.
- `oTick`, `oDone`, `oAborted` are pulses cleared on every edge where they are not set.

## Timing
- Start accepted at edge E. Tick k (k=1..B) is high for the cycle following edge E+k·(P+1).
- The last tick, `oDone`, and `oBusy` falling all happen at edge E+B·(P+1).
- A new `iStart` can be accepted at the first edge after `oBusy` falls. Back-to-back bursts are therefore spaced by at least one IDLE cycle.
- `oRemaining` updates on the same edge as each `oTick`.
- All outputs are registered. There are no combinational input-to-output paths.

## Test plan
- P=3, B=2, start at edge 0 -> `oTick` after edges 4 and 8. `oDone` after edge 8. `oBusy` high from edge 0 until edge 8. `oRemaining` goes 2→1→0.
- P=0, B=3 -> three consecutive `oTick` cycles after edges 1, 2, 3. `oDone` coincides with the third tick.
- B=0 start -> `oDone` one cycle after the start edge. `oBusy`, `oTick` stay 0.
- P=5, B=4, `iAbort` asserted at the terminal edge of tick 2 (edge 12) -> no tick at edge 12, `oAborted` pulse, `oRemaining`=3, no `oDone`.
- During a burst (P=2, B=3), pulse `iStart` with new `iPeriod`/`iBurst` -> ignored; ticks continue at 3-cycle spacing and exactly 3 ticks are emitted.
- `iRst` asserted mid-burst for one cycle -> next cycle all outputs 0, state IDLE, no `oDone`/`oAborted`. A subsequent start runs normally.
